// File: rtl/alu_exec_pkg.sv
// Shared types for the registered ALU execute stage.
// Opcode encodings, default width and FSM state type.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SUB2 = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SLT  = 4'b1010,
        OP_SRA  = 4'b1100,
        OP_MUL  = 4'b1111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/result bundle between the ALU decoder and alu_exec.
// Master drives operands; slave (alu_exec) returns results.
interface alu_exec_if #(
    parameter int XLEN = 32
);

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alucontrol;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            lt;
    logic            ltu;
    logic            illegal;

    modport master (
        output in_valid,
        output alucontrol,
        output a,
        output b,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero,
        input  lt,
        input  ltu,
        input  illegal
    );

    modport slave (
        input  in_valid,
        input  alucontrol,
        input  a,
        input  b,
        output in_ready,
        output out_valid,
        output result,
        output zero,
        output lt,
        output ltu,
        output illegal
    );

endinterface

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock.
// o_result is the accumulator including the current step's add.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplr;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic [XLEN-1:0] w_acc_n;

    assign w_acc_n  = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign o_busy   = r_busy;
    assign o_done   = r_busy && (r_cnt == LAST);
    assign o_result = w_acc_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_mplr  <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc   <= w_acc_n;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Registered ALU execute stage; 1-cycle ops, optional iterative mul.
// Define ALU_EXEC_MUL_EN to build the multiplier and MUL state.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_exec_if.slave   bus
);

    localparam int SW = $clog2(XLEN);

    logic            w_accept;
    logic            w_is_mul;
    logic            w_mul_done;
    logic            w_mul_lt;
    logic            w_mul_ltu;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_res;
    logic            w_ill;
    logic            w_lt;
    logic            w_ltu;
    logic [SW-1:0]   w_shamt;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_lt;
    logic            r_ltu;
    logic            r_illegal;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_lt     = $signed(bus.a) < $signed(bus.b);
    assign w_ltu    = bus.a < bus.b;
    assign w_shamt  = bus.b[SW-1:0];

`ifdef ALU_EXEC_MUL_EN
    exec_state_e r_state;
    exec_state_e w_state_n;
    logic        w_mul_start;
    logic        w_mul_busy;
    logic        r_lt_p;
    logic        r_ltu_p;

    assign bus.in_ready = (r_state == ST_IDLE);
    assign w_is_mul     = (bus.alucontrol == OP_MUL);
    assign w_mul_lt     = r_lt_p;
    assign w_mul_ltu    = r_ltu_p;

    mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_mul_start),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_result(w_mul_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_n   = ST_MUL;
                    w_mul_start = 1'b1;
                end
            end
            ST_MUL: begin
                // Never strand the core if the datapath has gone idle.
                if (w_mul_done || !w_mul_busy) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Flags of a mul come from its operands, captured at accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lt_p  <= 1'b0;
            r_ltu_p <= 1'b0;
        end else if (w_mul_start) begin
            r_lt_p  <= w_lt;
            r_ltu_p <= w_ltu;
        end
    end
`else
    assign bus.in_ready = 1'b1;
    assign w_is_mul     = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_res    = '0;
    assign w_mul_lt     = 1'b0;
    assign w_mul_ltu    = 1'b0;
`endif

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (bus.alucontrol)
            OP_ADD:          w_res = bus.a + bus.b;
            OP_SUB, OP_SUB2: w_res = bus.a - bus.b;
            OP_AND:          w_res = bus.a & bus.b;
            OP_OR:           w_res = bus.a | bus.b;
            OP_XOR:          w_res = bus.a ^ bus.b;
            OP_SLL:          w_res = bus.a << w_shamt;
            OP_SRL:          w_res = bus.a >> w_shamt;
            OP_SRA:          w_res = $signed(bus.a) >>> w_shamt;
            OP_SLT:          w_res = {{(XLEN-1){1'b0}}, w_lt};
            OP_SLTU:         w_res = {{(XLEN-1){1'b0}}, w_ltu};
`ifdef ALU_EXEC_MUL_EN
            OP_MUL:          w_res = '0;
`endif
            default:         w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_lt        <= w_lt;
            r_ltu       <= w_ltu;
            r_illegal   <= w_ill;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_zero      <= (w_mul_res == '0);
            r_lt        <= w_mul_lt;
            r_ltu       <= w_mul_ltu;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.lt        = r_lt;
    assign bus.ltu       = r_ltu;
    assign bus.illegal   = r_illegal;

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute stage directly downstream of the ALU decoder. Consumes the 4-bit `alucontrol` code with two operands, computes the result and branch flags, and presents them one cycle later. `mul` (code 4'b1111) runs on an iterative shift-add multiplier that deasserts `in_ready` while busy, so the core stalls.

## Interface

- `XLEN`, 32, operand and result width; must be a power of two ≥ 8.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: stage can accept; combinational from state.
- `alucontrol` input 4: operation code.
- `a`, `b` input XLEN: operands.
- `out_valid` output 1: one-cycle pulse, result/flags valid.
- `result` output XLEN: registered result.
- `zero` output 1: `result == 0`.
- `lt` output 1: signed `a < b` of the accepted op.
- `ltu` output 1: unsigned `a < b` of the accepted op.
- `illegal` output 1: accepted code unsupported.

## Operation

- Accept when `in_valid && in_ready`. There is no output backpressure; the consumer must take `out_valid` when pulsed.
- Codes:
  - 0010 add
  - 0110 / 0111 sub (a−b, wrap mod 2^XLEN)
  - 0000 and
  - 0001 or
  - 0011 xor
  - 0100 sll
  - 1000 srl
  - 1100 sra (shift amount `b[$clog2(XLEN)-1:0]`)
  - 1010 slt
  - 0101 sltu (zero-extended 0/1)
  - 1111 mul (low XLEN bits of the product; same for signed and unsigned)
- Any other code, including X: `result` = 0, `illegal` = 1, `zero` = 1, single-cycle path.
- `lt` and `ltu` are always computed from the accepted operands, including for mul and illegal codes.
- FSM states:
  - IDLE: `in_ready` = 1. A non-mul accept registers outputs at that edge and stays in IDLE. A mul accept loads multiplicand `a`, multiplier `b`, accumulator 0 and counter 0, and moves to MUL.
  - MUL: `in_ready` = 0; `in_valid` is ignored. Each edge: if `mplr[0]`, add `mcand` to `acc`; then `mcand <<= 1`, `mplr >>= 1`, counter +1. On the edge where the counter equals XLEN−1, register `result` and flags, pulse `out_valid`, and return to IDLE.

## Timing

- Non-mul latency is 1: accepted at edge E, `out_valid` is high in the cycle after E. Throughput is one op per cycle.
- Mul latency is XLEN: accepted at E, `out_valid` is high after edge E+XLEN (32 for the default). `in_ready` is low after E through edge E+XLEN.
- `in_ready` returns in the same cycle `out_valid` pulses, so a back-to-back accept is allowed.
- `out_valid` is high for exactly one cycle per accepted op. `result` and flags hold their last value until the next completion.
- Reset (asserted anywhere, including mid-mul) forces:
  - state IDLE
  - `out_valid` = 0, `result` = 0, `zero` = 0, `lt` = 0, `ltu` = 0, `illegal` = 0
  - counter and datapath registers cleared
- After reset, `in_ready` = 1. An aborted mul never produces `out_valid`.

## Configuration

- `ALU_EXEC_MUL_EN` defined: iterative multiplier and the MUL state are present, as described above.
- Not defined: no multiplier logic and no MUL state. Code 1111 is treated as illegal (`result` 0, `illegal` 1, 1-cycle latency), and `in_ready` is tied to 1.

## Structure

- Package `alu_pkg`:
  - `alu_op_e` enum, 4 bits, all codes above
  - `XLEN_DEF` = 32
  - FSM state enum `exec_state_e`
- Sub-module `mul_iter`: shift-add datapath and counter with `start`, `busy` and `done` signals, instantiated under `ALU_EXEC_MUL_EN`. `alu_exec` owns the FSM, the single-cycle datapath and the output registers.

## Test plan

- Reset then idle: `in_ready` = 1, every output 0. Assert `reset_n` low mid-op: `out_valid` never pulses for the aborted op.
- Back-to-back single-cycle ops: add 5+7 → 12; sub 3−5 → 0xFFFFFFFE with `lt` = 1, `ltu` = 1; sra 0x80000000 by 4 → 0xF8000000. Each completes after exactly 1 cycle, on consecutive cycles.
- Mul 0xFFFFFFFF × 3 → 0xFFFFFFFD:
  - `out_valid` exactly 32 cycles after accept
  - `in_ready` low for the whole wait
  - a held `in_valid` is accepted in the completion cycle
- Mul 0x10000 × 0x10000 → 0, `zero` = 1. Reset at cycle 10 of a mul: no `out_valid`, and a following add works.
- Illegal code 1001 → `result` 0, `illegal` 1, 1-cycle latency. With `ALU_EXEC_MUL_EN` undefined, 1111 behaves the same way.
- Random ops against a reference model (1000 ops, both macro settings): results, flags and latencies all match.
